// File: rtl/sample_buf_pkg.sv
// sample_buf_pkg
//   Shared types for the sample ring buffer.
//   DATA_W_DEFAULT : default PCM sample width (24-bit I2S capture).
//   rd_state_t     : read-side FSM states (IDLE / FETCH / VALID).
//   sample_t       : one signed sample at the default width.
package sample_buf_pkg;

    localparam int DATA_W_DEFAULT = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2
    } rd_state_t;

    typedef logic signed [DATA_W_DEFAULT-1:0] sample_t;

endpackage

// File: rtl/sample_sdp_ram.sv
// sample_sdp_ram
//   Simple dual-port RAM: one write port, one registered read port with a
//   single cycle of read latency. No reset on the array or the read register
//   so synthesis maps it onto block RAM.
//   Ports:
//     clk_i            clock
//     we_i/waddr_i/wdata_i   write port
//     re_i/raddr_i     read request; rdata_o valid on the following cycle
//     rdata_o          registered read data
module sample_sdp_ram #(
    parameter int DEPTH  = 1024,
    parameter int DATA_W = 24
) (
    input  logic                      clk_i,
    input  logic                      we_i,
    input  logic [$clog2(DEPTH)-1:0]  waddr_i,
    input  logic [DATA_W-1:0]         wdata_i,
    input  logic                      re_i,
    input  logic [$clog2(DEPTH)-1:0]  raddr_i,
    output logic [DATA_W-1:0]         rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_o <= mem[raddr_i];
        end
    end

endmodule

// File: rtl/sample_ring_buffer.sv
// sample_ring_buffer
//   Captures one channel of 24-bit PCM on each I2S capture strobe into a
//   circular buffer held in block RAM and serves the samples to a consumer
//   over a registered valid/ready output.
//   DEPTH must be a power of two and at least 4; READY_LEVEL is 1..DEPTH.
//   Ports:
//     clk_i, rst_ni     clock, asynchronous active-low reset
//     sample_valid_i    one-cycle capture strobe
//     left_sample_i     left channel sample
//     right_sample_i    right channel sample
//     clear_i           synchronous flush of pointers, fill, output, overflow
//     read_data_o       sample presented to the consumer
//     read_valid_o      read_data_o holds a sample
//     read_ready_i      consumer accepts
//     buffer_ready_o    fill level >= READY_LEVEL (registered)
//     fill_o            entries in RAM not yet fetched into the output register
//     overflow_o        sticky: a sample was dropped because the RAM was full
//     rd_state_o        current read FSM state, for observation
//
//   Output handshake: a sample transfers on a clock edge where read_valid_o
//   and read_ready_i are both 1. While read_valid_o=1 and read_ready_i=0 the
//   output register holds read_data_o unchanged. read_valid_o comes straight
//   from a flop and never depends combinationally on read_ready_i.
module sample_ring_buffer
    import sample_buf_pkg::*;
#(
    parameter int   DEPTH       = 1024,
    parameter int   DATA_W      = DATA_W_DEFAULT,
    parameter logic SELECT_LEFT = 1'b1,
    parameter int   READY_LEVEL = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      sample_valid_i,
    input  logic signed [DATA_W-1:0]  left_sample_i,
    input  logic signed [DATA_W-1:0]  right_sample_i,
    input  logic                      clear_i,
    output logic signed [DATA_W-1:0]  read_data_o,
    output logic                      read_valid_o,
    input  logic                      read_ready_i,
    output logic                      buffer_ready_o,
    output logic [$clog2(DEPTH):0]    fill_o,
    output logic                      overflow_o,
    output rd_state_t                 rd_state_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = AW + 1;

    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [FW-1:0]      fill;
    logic [FW-1:0]      fill_next;
    rd_state_t          state;

    logic               full;
    logic               has_data;
    logic               wr_accept;
    logic               fetch;
    logic [DATA_W-1:0]  sel_sample;
    logic [DATA_W-1:0]  ram_rdata;

    // Full/empty use the fill value before the edge, so a fetch in the same
    // cycle never makes room for a write to a full buffer. Because a write is
    // only accepted when not full and a fetch only issued when not empty, the
    // write and read addresses never coincide in the same cycle.
    always_comb begin
        full       = (fill == FW'(DEPTH));
        has_data   = (fill != '0);
        sel_sample = SELECT_LEFT ? left_sample_i : right_sample_i;
        wr_accept  = sample_valid_i && !full && !clear_i;
        fetch      = !clear_i && has_data &&
                     ((state == IDLE) || ((state == VALID) && read_ready_i));
        fill_next  = fill;
        case ({wr_accept, fetch})
            2'b10:   fill_next = fill + FW'(1);
            2'b01:   fill_next = fill - FW'(1);
            default: fill_next = fill;
        endcase
    end

    sample_sdp_ram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_accept),
        .waddr_i (wr_ptr),
        .wdata_i (sel_sample),
        .re_i    (fetch),
        .raddr_i (rd_ptr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            state          <= IDLE;
            read_valid_o   <= 1'b0;
            read_data_o    <= '0;
            buffer_ready_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else if (clear_i) begin
            // A strobe coinciding with clear is dropped silently.
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            fill           <= '0;
            state          <= IDLE;
            read_valid_o   <= 1'b0;
            buffer_ready_o <= 1'b0;
            overflow_o     <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (sample_valid_i && full) begin
                overflow_o <= 1'b1;
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            fill           <= fill_next;
            buffer_ready_o <= (fill_next >= FW'(READY_LEVEL));

            case (state)
                IDLE: begin
                    if (fetch) begin
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    // RAM data issued on the previous edge is available now.
                    read_data_o  <= ram_rdata;
                    read_valid_o <= 1'b1;
                    state        <= VALID;
                end
                VALID: begin
                    if (read_ready_i) begin
                        read_valid_o <= 1'b0;
                        state        <= has_data ? FETCH : IDLE;
                    end
                end
                default: begin
                    read_valid_o <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

    assign fill_o     = fill;
    assign rd_state_o = state;

endmodule

// File: tb/tb_sample_ring_buffer.sv
// tb_sample_ring_buffer
//   Two instances (left-select and right-select, DEPTH=8, READY_LEVEL=4) share
//   one stimulus stream and are compared every cycle against a queue-based
//   reference model of the buffer contents and output register.
module tb_sample_ring_buffer;
    import sample_buf_pkg::*;

    localparam int DEPTH = 8;
    localparam int RL    = 4;
    localparam int W     = 24;
    localparam int FW    = 4;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                 sv;
    logic signed [W-1:0]  left_s;
    logic signed [W-1:0]  right_s;
    logic                 clr;
    logic                 rdy;

    logic signed [W-1:0]  l_data,  r_data;
    logic                 l_valid, r_valid;
    logic                 l_bready, r_bready;
    logic [FW-1:0]        l_fill,  r_fill;
    logic                 l_ovf,   r_ovf;
    rd_state_t            l_state, r_state;

    sample_ring_buffer #(.DEPTH(DEPTH), .DATA_W(W), .SELECT_LEFT(1'b1), .READY_LEVEL(RL)) dut_l (
        .clk_i(clk), .rst_ni(rst_n), .sample_valid_i(sv),
        .left_sample_i(left_s), .right_sample_i(right_s), .clear_i(clr),
        .read_data_o(l_data), .read_valid_o(l_valid), .read_ready_i(rdy),
        .buffer_ready_o(l_bready), .fill_o(l_fill), .overflow_o(l_ovf),
        .rd_state_o(l_state)
    );

    sample_ring_buffer #(.DEPTH(DEPTH), .DATA_W(W), .SELECT_LEFT(1'b0), .READY_LEVEL(RL)) dut_r (
        .clk_i(clk), .rst_ni(rst_n), .sample_valid_i(sv),
        .left_sample_i(left_s), .right_sample_i(right_s), .clear_i(clr),
        .read_data_o(r_data), .read_valid_o(r_valid), .read_ready_i(rdy),
        .buffer_ready_o(r_bready), .fill_o(r_fill), .overflow_o(r_ovf),
        .rd_state_o(r_state)
    );

    // ---------------- scoreboard / reference model ----------------
    int vectors     = 0;
    int miscompares = 0;

    logic [2*W-1:0] exp_q[$];     // stored {left,right} pairs not yet fetched
    bit             m_pend;       // a fetched pair arrives in the output next edge
    logic [2*W-1:0] m_pend_d;
    bit             m_valid;
    logic [2*W-1:0] m_out;
    bit             m_ovf;
    bit             m_bready;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %06h expected %06h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_pend   = 1'b0;
        m_pend_d = '0;
        m_valid  = 1'b0;
        m_out    = '0;
        m_ovf    = 1'b0;
        m_bready = 1'b0;
    endtask

    task automatic model_edge(input bit s, input logic [W-1:0] l, input logic [W-1:0] r,
                              input bit rd, input bit c);
        int fill_before;
        bit was_full;
        bit take;
        if (c) begin
            exp_q.delete();
            m_pend   = 1'b0;
            m_valid  = 1'b0;
            m_ovf    = 1'b0;
            m_bready = 1'b0;
            return;
        end
        fill_before = exp_q.size();
        was_full    = (fill_before == DEPTH);
        take        = 1'b0;
        if (m_pend) begin
            m_valid = 1'b1;
            m_out   = m_pend_d;
            m_pend  = 1'b0;
        end else if (!m_valid) begin
            take = (fill_before > 0);
        end else if (rd) begin
            m_valid = 1'b0;
            take    = (fill_before > 0);
        end
        if (take) begin
            m_pend_d = exp_q.pop_front();
            m_pend   = 1'b1;
        end
        if (s) begin
            if (was_full) m_ovf = 1'b1;
            else          exp_q.push_back({l, r});
        end
        m_bready = (exp_q.size() >= RL);
    endtask

    task automatic check_all();
        chk("l_valid",  W'(l_valid),  W'(m_valid));
        chk("l_data",   W'(l_data),   m_out[2*W-1:W]);
        chk("l_fill",   W'(l_fill),   W'(exp_q.size()));
        chk("l_bready", W'(l_bready), W'(m_bready));
        chk("l_ovf",    W'(l_ovf),    W'(m_ovf));
        chk("r_valid",  W'(r_valid),  W'(m_valid));
        chk("r_data",   W'(r_data),   m_out[W-1:0]);
        chk("r_fill",   W'(r_fill),   W'(exp_q.size()));
    endtask

    // ---------------- driver ----------------
    task automatic cycle(input bit s, input logic [W-1:0] l, input logic [W-1:0] r,
                         input bit rd, input bit c);
        sv      = s;
        left_s  = l;
        right_s = r;
        rdy     = rd;
        clr     = c;
        @(posedge clk);
        model_edge(s, l, r, rd, c);
        #1;
        check_all();
    endtask

    task automatic idle(input bit rd);
        cycle(1'b0, W'($urandom), W'($urandom), rd, 1'b0);
    endtask

    // ---------------- test sequence ----------------
    logic [W-1:0] held;
    int           k;

    initial begin
        sv = 0; left_s = '0; right_s = '0; clr = 0; rdy = 0;
        model_reset();
        #12;
        check_all();
        chk("reset_state", W'(l_state), W'(IDLE));
        rst_n = 1'b1;

        // Three samples, consumer always ready; first valid on the 2nd edge.
        cycle(1'b1, 24'h000123, 24'h0A0A0A, 1'b1, 1'b0);
        chk("lat_edge0", W'(l_valid), 24'd0);
        cycle(1'b1, 24'h7FFFFF, 24'h0B0B0B, 1'b1, 1'b0);
        chk("lat_edge1", W'(l_valid), 24'd0);
        cycle(1'b1, 24'h800000, 24'h0C0C0C, 1'b1, 1'b0);
        chk("lat_edge2", W'(l_valid), 24'd1);
        chk("first_data", W'(l_data), 24'h000123);
        for (int i = 0; i < 8; i++) idle(1'b1);
        chk("drained_fill", W'(l_fill), 24'd0);

        // Channel selection.
        cycle(1'b1, 24'h111111, 24'hFFFFFE, 1'b0, 1'b0);
        idle(1'b0);
        idle(1'b0);
        chk("sel_right", W'(r_data), 24'hFFFFFE);
        chk("sel_left",  W'(l_data), 24'h111111);
        for (int i = 0; i < 4; i++) idle(1'b1);

        // Stalled consumer: fill to full, then overflow on the 10th strobe.
        for (int i = 1; i <= 10; i++) begin
            cycle(1'b1, W'(i), ~W'(i), 1'b0, 1'b0);
            if (i == 4)  chk("bready_fill3", W'(l_bready), 24'd0);
            if (i == 5)  chk("bready_fill4", W'(l_bready), 24'd1);
            if (i == 8)  chk("stall_fill7",  W'(l_fill),   24'd7);
            if (i == 9)  chk("stall_fill8",  W'(l_fill),   24'd8);
            if (i == 9)  chk("no_ovf_yet",   W'(l_ovf),    24'd0);
            if (i == 10) chk("ovf_set",      W'(l_ovf),    24'd1);
        end
        held = l_data;
        for (int i = 0; i < 4; i++) cycle(i[0], 24'h5A5A5A, 24'hA5A5A5, 1'b0, 1'b0);
        chk("stall_hold", held, 24'd1);
        chk("stall_data", W'(l_data), 24'd1);

        // Drain down to fill 5, then clear with a coincident strobe.
        k = 0;
        while (exp_q.size() > 5 && k < 20) begin
            idle(1'b1);
            k++;
        end
        chk("pre_clear_fill", W'(l_fill), 24'd5);
        chk("pre_clear_ovf",  W'(l_ovf),  24'd1);
        cycle(1'b1, 24'hABCDEF, 24'hABCDEF, 1'b0, 1'b1);
        chk("clr_fill",  W'(l_fill),  24'd0);
        chk("clr_valid", W'(l_valid), 24'd0);
        chk("clr_ovf",   W'(l_ovf),   24'd0);
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("clr_not_emitted", W'(l_valid), 24'd0);

        // Simultaneous accepted write and fetch keep fill unchanged.
        cycle(1'b1, 24'h000010, 24'h000020, 1'b0, 1'b0);
        cycle(1'b1, 24'h000011, 24'h000021, 1'b0, 1'b0);
        cycle(1'b1, 24'h000012, 24'h000022, 1'b0, 1'b0);
        idle(1'b0);
        chk("pre_wf_fill", W'(l_fill), 24'd2);
        cycle(1'b1, 24'h000013, 24'h000023, 1'b1, 1'b0);
        chk("wr_fetch_fill", W'(l_fill), 24'd2);

        // Randomized traffic with alternating consumer pressure.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 70; i++) begin
                cycle($urandom_range(0, 2) == 0,
                      W'($urandom), W'($urandom),
                      (p[0] == 1'b0) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0),
                      $urandom_range(0, 149) == 0);
            end
        end

        // Async reset while a fetch is in flight.
        for (int i = 0; i < 30; i++) idle(1'b1);
        cycle(1'b1, 24'h123456, 24'h654321, 1'b0, 1'b0);
        idle(1'b0);
        chk("in_fetch", W'(l_state), W'(FETCH));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid",  W'(l_valid),  24'd0);
        chk("arst_data",   W'(l_data),   24'd0);
        chk("arst_fill",   W'(l_fill),   24'd0);
        chk("arst_bready", W'(l_bready), 24'd0);
        chk("arst_ovf",    W'(l_ovf),    24'd0);
        chk("arst_state",  W'(l_state),  W'(IDLE));
        model_reset();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            cycle($urandom_range(0, 1) == 0, W'($urandom), W'($urandom),
                  $urandom_range(0, 1) == 0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
